// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the nibble-serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE = 4;

    function automatic int cnt_width(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

    localparam int NIB_W = cnt_width(16 / NIBBLE);

endpackage

// File: rtl/ripple_adder_4bit.sv
// rtl/ripple_adder_4bit.sv - 4-bit ripple-carry adder, shared datapath of the serial adder
module ripple_adder_4bit
    import serial_add_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] sum,
    output logic              cout
);

    logic [NIBBLE:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIBBLE];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - WIDTH-bit adder using one 4-bit adder, one nibble per cycle, LSB first
// Optional subtract mode (port sub) under macro SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE;
    localparam int CW  = cnt_width(NIB);

    state_t            state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [NIBBLE-1:0] add_s;
    logic              add_co;
    logic [WIDTH+NIBBLE-1:0] sum_cat;

    logic [WIDTH-1:0]  b_load;
    logic              c_load;

`ifdef SERIAL_ADD_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    ripple_adder_4bit u_adder (
        .a    (a_sh[NIBBLE-1:0]),
        .b    (b_sh[NIBBLE-1:0]),
        .cin  (carry),
        .sum  (add_s),
        .cout (add_co)
    );

    // New nibble enters at the MSB side; the concat keeps WIDTH=4 free of empty slices.
    assign sum_cat = {add_s, sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b_load;
                        carry    <= c_load;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> NIBBLE;
                    b_sh  <= b_sh >> NIBBLE;
                    sum   <= sum_cat[WIDTH+NIBBLE-1:NIBBLE];
                    carry <= add_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NIB - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        cout      <= add_co;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl against an arithmetic reference
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
        if (s) return {1'b0, x} - {1'b0, y} + 17'h10000;
        return {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    // Entered and left at posedge+1; hold = cycles of out_ready=0 once the result is up.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic sv, input int hold);
        logic [16:0] exp;
        int k;
        exp = ref_add(av, bv, cv, sv);
        check("in_ready_idle", in_ready, 1);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        check("in_ready_run", in_ready, 0);
        check("busy_run", busy, 1);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, 4);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            check("hold_sum", sum, exp[15:0]);
            check("hold_cout", cout, exp[16]);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_busy", busy, 1);
        end
        in_valid = 1'b0;
        check("sum", sum, exp[15:0]);
        check("cout", cout, exp[16]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        do_op(16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        do_op(16'h00A0, 16'h0050, 1'b0, 1'b0, 6);
        do_op(16'h1111, 16'h2222, 1'b1, 1'b0, 0);

        // Abort in the second RUN cycle
        a = 16'h8888; b = 16'h8888; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

        for (int t = 0; t < 30; t++) begin
`ifdef SERIAL_ADD_SUB_EN
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
`else
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
